// File: rtl/rggen_apb_master_bridge_pkg.sv
// rtl/rggen_apb_master_bridge_pkg.sv - shared types and constants for the APB master bridge
//
// Contents:
//   bridge_state_e  : FSM states IDLE / SETUP / ACCESS / RESPONSE
//   bridge_status_e : response status codes OKAY / SLVERR / TIMEOUT
//   PPROT_DEFAULT   : fixed APB protection attribute driven on o_pprot
package rggen_apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SETUP    = 2'b01,
    ST_ACCESS   = 2'b10,
    ST_RESPONSE = 2'b11
  } bridge_state_e;

  typedef enum logic [1:0] {
    STATUS_OKAY    = 2'b00,
    STATUS_SLVERR  = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } bridge_status_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rggen_apb_master_bridge_timer.sv
// rtl/rggen_apb_master_bridge_timer.sv - ACCESS-phase wait-state counter with terminal-count detect
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : zero the count (asserted the cycle before ACCESS is entered)
//   i_count     : this is an ACCESS cycle without i_pready
//   o_terminal  : this un-ready ACCESS cycle is the TIMEOUT_CYCLES-th one
module rggen_apb_master_bridge_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_terminal
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The count holds the number of un-ready cycles already elapsed, so the
  // current cycle is the terminal one when the count is one short of the limit.
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_terminal = i_count && (count_q == LAST_COUNT);

endmodule

// File: rtl/rggen_apb_master_bridge.sv
// rtl/rggen_apb_master_bridge.sv - valid/ready request/response to APB4 master bridge
//
// Optional feature macro: RGGEN_APB_MASTER_BRIDGE_TIMEOUT_EN (ACCESS-phase timeout)
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_req_* / o_req_ready  : request channel (write, byte address, data, strobes)
//   o_rsp_* / i_rsp_ready  : response channel (read data, 2-bit status)
//   o_p* / i_p*            : APB4 master interface
module rggen_apb_master_bridge
  import rggen_apb_master_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
  input  logic [DATA_WIDTH-1:0]     i_req_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_req_strobe,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]                o_rsp_status,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  output logic [2:0]                o_pprot,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  localparam int BYTE_LANES = DATA_WIDTH / 8;
  // Clears the byte-offset bits so the APB address is bus-word aligned.
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(BYTE_LANES - 1);

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  bridge_state_e              state_q, state_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [BYTE_LANES-1:0]      pstrb_q, pstrb_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]      rsp_read_data_q, rsp_read_data_d;
  bridge_status_e             rsp_status_q, rsp_status_d;
  logic                       timeout_hit;

`ifdef RGGEN_APB_MASTER_BRIDGE_TIMEOUT_EN
  rggen_apb_master_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (state_q == ST_SETUP),
    .i_count    ((state_q == ST_ACCESS) && !i_pready),
    .o_terminal (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    psel_d          = psel_q;
    penable_d       = penable_q;
    pwrite_d        = pwrite_q;
    paddr_d         = paddr_q;
    pwdata_d        = pwdata_q;
    pstrb_d         = pstrb_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_read_data_d = rsp_read_data_q;
    rsp_status_d    = rsp_status_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = i_req_write;
          paddr_d   = i_req_address & ADDR_MASK;
          // Reads never present stale write data or strobes on the bus.
          pwdata_d  = i_req_write ? i_req_write_data : '0;
          pstrb_d   = i_req_write ? i_req_strobe : '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready slave takes priority over a simultaneous terminal count.
        if (i_pready) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          rsp_valid_d     = 1'b1;
          rsp_read_data_d = pwrite_q ? '0 : i_prdata;
          rsp_status_d    = i_pslverr ? STATUS_SLVERR : STATUS_OKAY;
          state_d         = ST_RESPONSE;
        end else if (timeout_hit) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          rsp_valid_d     = 1'b1;
          rsp_read_data_d = '0;
          rsp_status_d    = STATUS_TIMEOUT;
          state_d         = ST_RESPONSE;
        end
      end
      ST_RESPONSE: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      psel_q          <= 1'b0;
      penable_q       <= 1'b0;
      pwrite_q        <= 1'b0;
      paddr_q         <= '0;
      pwdata_q        <= '0;
      pstrb_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_read_data_q <= '0;
      rsp_status_q    <= STATUS_OKAY;
    end else begin
      state_q         <= state_d;
      psel_q          <= psel_d;
      penable_q       <= penable_d;
      pwrite_q        <= pwrite_d;
      paddr_q         <= paddr_d;
      pwdata_q        <= pwdata_d;
      pstrb_q         <= pstrb_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_read_data_q <= rsp_read_data_d;
      rsp_status_q    <= rsp_status_d;
    end
  end

  // Every output comes straight from state or a flop: no input-to-output path.
  assign o_req_ready     = (state_q == ST_IDLE);
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_read_data = rsp_read_data_q;
  assign o_rsp_status    = rsp_status_q;
  assign o_psel          = psel_q;
  assign o_penable       = penable_q;
  assign o_pwrite        = pwrite_q;
  assign o_paddr         = paddr_q;
  assign o_pwdata        = pwdata_q;
  assign o_pstrb         = pstrb_q;
  assign o_pprot         = PPROT_DEFAULT;

endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// tb/tb_rggen_apb_master_bridge.sv - self-checking bench for rggen_apb_master_bridge
module tb_rggen_apb_master_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic [3:0]  req_strobe = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_read_data;
  logic [1:0]  rsp_status;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  rggen_apb_master_bridge #(
    .ADDRESS_WIDTH  (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_address    (req_address),
    .i_req_write_data (req_write_data),
    .i_req_strobe     (req_strobe),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_read_data  (rsp_read_data),
    .o_rsp_status     (rsp_status),
    .o_psel           (psel),
    .o_penable        (penable),
    .o_pwrite         (pwrite),
    .o_paddr          (paddr),
    .o_pwdata         (pwdata),
    .o_pstrb          (pstrb),
    .o_pprot          (pprot),
    .i_pready         (pready),
    .i_prdata         (prdata),
    .i_pslverr        (pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_req();
    req_write      = 1'($urandom);
    req_address    = 16'($urandom);
    req_write_data = $urandom;
    req_strobe     = 4'($urandom);
  endtask

  // Transaction-level model: expected bus image and response derived from
  // the request fields and the slave behaviour chosen by the caller.
  // Called at a falling edge with the bridge idle; returns at a falling edge
  // with the bridge idle again. ws = wait states before pready (a large
  // value means the slave never answers).
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int ws, input bit err,
                        input logic [31:0] rd, input int hold, input bit noisy);
    int          n_acc;
    bit          timed_out;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    logic [31:0] e_rd;
    logic [1:0]  e_status;

    e_addr    = addr & 16'hFFFC;
    e_wd      = wr ? wd : 32'h0;
    e_st      = wr ? st : 4'h0;
    n_acc     = ws + 1;
    timed_out = 1'b0;
`ifdef RGGEN_APB_MASTER_BRIDGE_TIMEOUT_EN
    if (ws >= TO) begin
      n_acc     = TO;
      timed_out = 1'b1;
    end
`endif
    e_rd     = (wr || timed_out) ? 32'h0 : rd;
    e_status = timed_out ? 2'b10 : (err ? 2'b01 : 2'b00);

    check("idle_req_ready", req_ready, 1);
    check("idle_psel", psel, 0);
    req_valid      = 1'b1;
    req_write      = wr;
    req_address    = addr;
    req_write_data = wd;
    req_strobe     = st;

    // SETUP
    @(negedge clk);
    if (noisy) scramble_req(); else req_valid = 1'b0;
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_req_ready", req_ready, 0);
    check("setup_pwrite", pwrite, wr);
    check("setup_paddr", paddr, e_addr);
    check("setup_pwdata", pwdata, e_wd);
    check("setup_pstrb", pstrb, e_st);
    check("setup_rsp_valid", rsp_valid, 0);

    // ACCESS
    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      if (noisy) scramble_req();
      check("access_psel", psel, 1);
      check("access_penable", penable, 1);
      check("access_req_ready", req_ready, 0);
      check("access_rsp_valid", rsp_valid, 0);
      check("access_paddr", paddr, e_addr);
      check("access_pwrite", pwrite, wr);
      check("access_pwdata", pwdata, e_wd);
      check("access_pstrb", pstrb, e_st);
      pready = (k == ws);
      if (k == ws) begin
        prdata  = rd;
        pslverr = err;
      end else begin
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end

    // RESPONSE, held for 'hold' extra cycles before the handshake
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (noisy) scramble_req();
      pready  = 1'b0;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_read_data", rsp_read_data, e_rd);
      check("rsp_status", rsp_status, e_status);
      check("rsp_psel", psel, 0);
      check("rsp_penable", penable, 0);
      check("rsp_req_ready", req_ready, 0);
      rsp_ready = (h == hold);
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_rsp_data", rsp_read_data, 0);
    check("rst_rsp_status", rsp_status, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pprot", pprot, 0);
    check("idle_after_rst_psel", psel, 0);

    // Directed: write, no wait states
    do_txn(1'b1, 16'h0012, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h0, 0, 1'b0);
    // Directed: read, 3 wait states
    do_txn(1'b0, 16'h0008, 32'hAAAA5555, 4'b1111, 3, 1'b0, 32'h12345678, 0, 1'b0);
    // Directed: read with slave error, response held 5 cycles
    do_txn(1'b0, 16'h0104, 32'h0, 4'b0000, 1, 1'b1, 32'hCAFEF00D, 5, 1'b0);
    // Directed: back-to-back with request valid held high throughout
    do_txn(1'b1, 16'h0020, 32'h11223344, 4'b1111, 0, 1'b0, 32'h0, 0, 1'b1);
    do_txn(1'b0, 16'h0027, 32'h0, 4'b0000, 0, 1'b0, 32'h55667788, 0, 1'b1);
    req_valid = 1'b0;

`ifdef RGGEN_APB_MASTER_BRIDGE_TIMEOUT_EN
    // Slave never answers, then answers exactly on the terminal cycle
    do_txn(1'b0, 16'h0030, 32'h0, 4'b0000, 1000, 1'b0, 32'h0, 1, 1'b0);
    do_txn(1'b0, 16'h0034, 32'h0, 4'b0000, TO - 1, 1'b0, 32'h0BADCAFE, 0, 1'b0);
`endif

    // Reset during ACCESS
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 16'h0044;
    req_write_data = 32'h01020304;
    req_strobe  = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    pready    = 1'b0;
    @(negedge clk);
    check("pre_rst_penable", penable, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_paddr", paddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("after_rst_rsp_valid", rsp_valid, 0);
      check("after_rst_req_ready", req_ready, 1);
      check("after_rst_psel", psel, 0);
    end
    do_txn(1'b1, 16'h0046, 32'h0A0B0C0D, 4'b0101, 2, 1'b0, 32'h0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 7)), 1'($urandom), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom));
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("final_req_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_apb_master_bridge.md
Name: rggen_apb_master_bridge

Overview:
- Upstream feeder for generated APB register blocks.
- Converts a simple valid/ready request/response bus into APB4 master transfers: SETUP then ACCESS.
- One outstanding transaction.
- Sits between a CPU/DMA-side fabric port and the register block's APB slave interface.
- Optional timeout protects the fabric against a slave that never asserts i_pready.

Parameters:
ADDRESS_WIDTH, 16, byte address width of request and APB address.
DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64.
TIMEOUT_CYCLES, 64, ACCESS-phase cycles without i_pready before forced termination; minimum 1; used only when the optional feature is enabled.

Ports:
clk  input  1  clock; all logic rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
i_req_valid  input  1  request valid.
o_req_ready  output  1  request accepted when high together with i_req_valid.
i_req_write  input  1  1 = write, 0 = read.
i_req_address  input  ADDRESS_WIDTH  byte address.
i_req_write_data  input  DATA_WIDTH  write data.
i_req_strobe  input  DATA_WIDTH/8  byte enables for writes.
o_rsp_valid  output  1  response valid.
i_rsp_ready  input  1  response consumed.
o_rsp_read_data  output  DATA_WIDTH  read data; 0 for writes.
o_rsp_status  output  2  00 OKAY, 01 SLVERR, 10 TIMEOUT.
o_psel  output  1  APB select.
o_penable  output  1  APB enable.
o_pwrite  output  1  APB direction.
o_paddr  output  ADDRESS_WIDTH  APB address.
o_pwdata  output  DATA_WIDTH  APB write data.
o_pstrb  output  DATA_WIDTH/8  APB strobes.
o_pprot  output  3  fixed 3'b000.
i_pready  input  1  APB ready.
i_prdata  input  DATA_WIDTH  APB read data.
i_pslverr  input  1  APB error.

Behaviour:
- Reset (async assert, sync deassert to clk by system): state IDLE.
  - o_req_ready=1; o_rsp_valid=0; o_rsp_read_data=0; o_rsp_status=00.
  - o_psel=0; o_penable=0; o_pwrite=0; o_paddr=0; o_pwdata=0; o_pstrb=0.
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE:
  - o_req_ready=1; all APB outputs registered.
  - On i_req_valid (handshake cycle T): capture request into APB output registers.
    - o_paddr = address with low log2(DATA_WIDTH/8) bits forced to 0.
    - Reads: o_pstrb=0, o_pwdata=0.
  - Next state SETUP.
- SETUP (T+1): o_psel=1, o_penable=0, o_req_ready=0; unconditional transition to ACCESS.
- ACCESS (T+2 onward): o_psel=1, o_penable=1.
  - o_paddr, o_pwrite, o_pwdata, o_pstrb held stable.
  - On i_pready=1:
    - Reads: register i_prdata into o_rsp_read_data; writes: o_rsp_read_data=0.
    - o_rsp_status = i_pslverr ? 01 : 00.
    - o_psel=0, o_penable=0 next cycle; go RESPONSE.
- RESPONSE: o_rsp_valid=1; all response outputs held stable until i_rsp_ready=1, then IDLE.
  - rsp_valid must never drop without the handshake.
- Minimum latency: handshake at T, rsp_valid at T+3 with zero APB wait states.
- Minimum period per transaction: 4 cycles.
- o_req_ready is low in SETUP, ACCESS and RESPONSE; no request is accepted in those states.
- i_pslverr and i_prdata are sampled only when o_psel & o_penable & i_pready.
- Reset mid-transfer: APB outputs drop immediately; the transaction is discarded and no response is produced.
- No combinational path from any input to any output.

Optional Feature:
- Macro: RGGEN_APB_MASTER_BRIDGE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle with i_pready=0.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - When the count equals TIMEOUT_CYCLES with i_pready=0: drop o_psel/o_penable, set o_rsp_read_data=0 and o_rsp_status=10, go RESPONSE.
  - i_pready arriving in the same cycle as the terminal count wins, giving a normal completion.
- Not defined: no counter; ACCESS waits indefinitely; status 10 is never produced.

Decomposition:
- Package rggen_apb_master_bridge_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESPONSE);
  - the status enum (OKAY/SLVERR/TIMEOUT);
  - the constant for the 3'b000 pprot value.
- Optional sub-module rggen_apb_master_bridge_timer: counter plus terminal-count compare, instantiated only under the macro.

Test Plan:
- Write addr 0x0012, data 0xDEADBEEF, strobe 4'b0011, pready at first ACCESS cycle.
  - o_paddr=0x0010, o_pstrb=0011, SETUP at T+1, ACCESS at T+2.
  - rsp_valid at T+3, status 00, read_data 0.
- Read addr 0x0008, 3 wait states, prdata 0x12345678.
  - ACCESS lasts 4 cycles, APB outputs stable throughout.
  - o_rsp_read_data=0x12345678, o_pstrb=0.
- Read with pslverr=1 on the ready cycle -> status 01.
  - Then hold i_rsp_ready=0 for 5 cycles -> rsp_valid and data held; o_req_ready stays 0.
- Back-to-back requests with i_req_valid held high -> second accepted exactly 1 cycle after the first response handshake.
- Macro defined, TIMEOUT_CYCLES=4, pready never asserted -> status 10 after 4 ACCESS cycles, psel drops.
  - Repeat with pready on the terminal cycle -> status 00.
- rst_n asserted during ACCESS -> psel/penable 0 asynchronously.
  - After release: no rsp_valid, o_req_ready=1, next transaction completes normally.
